controlador_interrupciones: RTL
===============================

CONTROLADOR_INTERRUPCIONES -- requirements
Module: controlador_interrupciones

Interface
REQ-001 Parameter N_FUENTES, default 8, SHALL set the number of interrupt sources (1..8).
REQ-002 Port clk  input  1  SHALL be the single clock; all state changes on its rising edge.
REQ-003 Port reset  input  1  SHALL be the reset; synchronous, active-low.
REQ-004 Port fuentes  input  N_FUENTES  SHALL carry raw request lines from the timer and the I/O manager.
REQ-005 Port we  input  1  SHALL be the register write strobe from the I/O manager.
REQ-006 Port dir  input  2  SHALL select the register: 0 mask, 1 pending, 2 status, 3 lost counter.
REQ-007 Port dato_in  input  8  SHALL be the write data.
REQ-008 Port dato_out  output  8  SHALL be the combinational read data for dir.
REQ-009 Port irq  output  1  SHALL be the registered interrupt request to the CPU.
REQ-010 Port vector  output  3  SHALL be the registered index of the source being requested or served.
REQ-011 Port ack  input  1  SHALL be the CPU acknowledge, one-cycle pulse.
REQ-012 Port fin  input  1  SHALL be the CPU end-of-service pulse.

Function
REQ-013 Each source SHALL be rising-edge detected against a one-cycle delayed copy; an edge sets its pending bit on the same clock edge that samples fuentes=1 with previous=0.
REQ-014 A pending bit set and clear in the same cycle SHALL resolve to set.
REQ-015 Writing dir=1 SHALL clear the pending bits where dato_in is 1 (write-one-to-clear); writing dir=0 SHALL load the mask; dir=2,3 writes SHALL be ignored.
REQ-016 FSM states REPOSO, PETICION, SERVICIO; REPOSO->PETICION when (pending & mask) != 0, latching vector = lowest-index active bit (index 0 highest priority).
REQ-017 irq SHALL be 1 exactly while in PETICION; first assertion one cycle after the pending bit sets.
REQ-018 PETICION->SERVICIO on ack, clearing pending[vector] on that edge; vector held stable until return to REPOSO.
REQ-019 SERVICIO->REPOSO on fin; no nesting, a new request is raised no earlier than the cycle after fin.
REQ-020 ack outside PETICION and fin outside SERVICIO SHALL be ignored.
REQ-021 Mask changes or a clear of pending[vector] during PETICION SHALL NOT retract irq or change vector.
REQ-022 dato_out for dir=2 SHALL be {3'b0, state[1:0], vector}; unused pending/mask bits above N_FUENTES read 0.

Reset
REQ-023 While reset=0 at a clock edge: state REPOSO, irq=0, vector=0, mask=8'h00, pending=0, edge history=0, lost counter=0.
REQ-024 Reset mid-service SHALL abandon the service; a source still high after reset SHALL NOT generate an edge.

Configuration
REQ-025 With macro CTRL_INT_PERDIDAS_EN defined, an edge on a source whose pending bit is already 1 SHALL increment an 8-bit lost counter saturating at 255, readable at dir=3, cleared by any write to dir=3.
REQ-026 Without CTRL_INT_PERDIDAS_EN, no counter SHALL be built, dir=3 SHALL read 0 and writes to it are ignored.

Structure
REQ-027 A shared package SHALL hold the FSM state encoding (REPOSO=0, PETICION=1, SERVICIO=2) and the register address constants.
REQ-028 The priority encoder SHALL be a sub-module codificador_prioridad (N-bit request in, 3-bit index plus valid out, combinational).

Verification
REQ-029 Mask=8'h01, timer pulse on fuentes[0] -> pending=1 next edge, irq=1 one cycle later, vector=0; ack -> irq=0, pending=0; fin -> state REPOSO.
REQ-030 Mask=8'hFF, edges on fuentes[5] and fuentes[2] same cycle -> vector=2 first; after ack+fin -> vector=5 raised.
REQ-031 Mask=8'h00, edge on fuentes[3] -> pending=8'h08, irq stays 0; write mask=8'h08 -> irq=1 next cycle, vector=3.
REQ-032 In PETICION, write mask=8'h00 -> irq stays 1, vector unchanged; write 8'hFF to dir=1 while fuentes[1] edges same cycle -> pending[1]=1.
REQ-033 With CTRL_INT_PERDIDAS_EN, three edges on fuentes[0] while pending[0]=1 -> dir=3 reads 3; 300 such edges -> reads 255; without macro -> reads 0.
REQ-034 reset=0 during SERVICIO with fuentes[4] held high -> all outputs 0 next edge; after release no request from source 4 until it falls and rises again.

Source files
------------

// File: rtl/controlador_interrupciones_pkg.sv
// Shared definitions for the interrupt controller: FSM state encoding,
// register map and saturating-counter helpers.
package controlador_interrupciones_pkg;

   localparam int ANCHO_VECTOR = 3;

   typedef enum logic [1:0] {
      REPOSO   = 2'd0,
      PETICION = 2'd1,
      SERVICIO = 2'd2
   } estado_t;

   localparam logic [1:0] DIR_MASCARA   = 2'd0;
   localparam logic [1:0] DIR_PENDIENTE = 2'd1;
   localparam logic [1:0] DIR_ESTADO    = 2'd2;
   localparam logic [1:0] DIR_PERDIDAS  = 2'd3;

   function automatic logic [3:0] cuenta_unos(input logic [7:0] v);
      logic [3:0] n;
      n = 4'd0;
      for (int i = 0; i < 8; i++) begin
         n = n + {3'd0, v[i]};
      end
      return n;
   endfunction

   function automatic logic [7:0] suma_saturada(input logic [7:0] cnt, input logic [3:0] inc);
      logic [8:0] s;
      s = {1'b0, cnt} + {5'd0, inc};
      return (s > 9'd255) ? 8'hFF : s[7:0];
   endfunction

endpackage

// File: rtl/controlador_interrupciones_codificador_prioridad.sv
// Combinational priority encoder: lowest set request index wins.
module codificador_prioridad
   import controlador_interrupciones_pkg::*;
#(
   parameter int N = 8
) (
   input  logic [N-1:0]              peticion,
   output logic [ANCHO_VECTOR-1:0]   indice,
   output logic                      valido
);

   // Scan from the top so the lowest active index is the last one written
   always_comb begin
      indice = '0;
      valido = 1'b0;
      for (int i = N - 1; i >= 0; i--) begin
         indice = peticion[i] ? ANCHO_VECTOR'(i) : indice;
         valido = valido | peticion[i];
      end
   end

endmodule

// File: rtl/controlador_interrupciones.sv
// Interrupt controller: edge-detected sources, W1C pending, mask, 3-state
// request/service handshake. Optional lost-edge counter: CTRL_INT_PERDIDAS_EN.
module controlador_interrupciones
   import controlador_interrupciones_pkg::*;
#(
   parameter int N_FUENTES = 8
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [N_FUENTES-1:0] fuentes,
   input  logic                 we,
   input  logic [1:0]           dir,
   input  logic [7:0]           dato_in,
   output logic [7:0]           dato_out,
   output logic                 irq,
   output logic [2:0]           vector,
   input  logic                 ack,
   input  logic                 fin
);

   logic [N_FUENTES-1:0]    previo_r;
   logic [N_FUENTES-1:0]    bloqueo_r;
   logic [N_FUENTES-1:0]    pendiente_r;
   logic [N_FUENTES-1:0]    mascara_r;
   logic [N_FUENTES-1:0]    pendiente_sig_s;
   logic [N_FUENTES-1:0]    flanco_s;
   logic [N_FUENTES-1:0]    activo_s;
   estado_t                 estado_r;
   estado_t                 estado_sig_s;
   logic                    irq_r;
   logic                    irq_sig_s;
   logic [2:0]              vector_r;
   logic [2:0]              vector_sig_s;
   logic [ANCHO_VECTOR-1:0] indice_s;
   logic                    valido_s;
   logic                    ack_valido_s;
   logic [7:0]              perdidas_lect_s;
   logic [7:0]              mascara_ext_s;
   logic [7:0]              pendiente_ext_s;

   // bloqueo_r keeps a source that is high across reset from looking like an edge
   assign flanco_s     = fuentes & ~previo_r & ~bloqueo_r;
   assign activo_s     = pendiente_r & mascara_r;
   assign ack_valido_s = ack && (estado_r == PETICION);

   codificador_prioridad #(.N(N_FUENTES)) u_codificador (
      .peticion (activo_s),
      .indice   (indice_s),
      .valido   (valido_s)
   );

   always_ff @(posedge clk) begin
      if (!reset) begin
         previo_r  <= '0;
         bloqueo_r <= fuentes;
      end else begin
         previo_r  <= fuentes;
         bloqueo_r <= '0;
      end
   end

   // Clears first, then new edges, so a simultaneous set wins
   always_comb begin
      pendiente_sig_s = pendiente_r;
      if (we && (dir == DIR_PENDIENTE)) begin
         pendiente_sig_s = pendiente_sig_s & ~dato_in[N_FUENTES-1:0];
      end else begin
         pendiente_sig_s = pendiente_sig_s;
      end
      if (ack_valido_s) begin
         pendiente_sig_s[vector_r] = 1'b0;
      end else begin
         pendiente_sig_s = pendiente_sig_s;
      end
      pendiente_sig_s = pendiente_sig_s | flanco_s;
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         pendiente_r <= '0;
         mascara_r   <= '0;
      end else begin
         pendiente_r <= pendiente_sig_s;
         if (we && (dir == DIR_MASCARA)) begin
            mascara_r <= dato_in[N_FUENTES-1:0];
         end else begin
            mascara_r <= mascara_r;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         estado_r <= REPOSO;
         irq_r    <= 1'b0;
         vector_r <= 3'd0;
      end else begin
         estado_r <= estado_sig_s;
         irq_r    <= irq_sig_s;
         vector_r <= vector_sig_s;
      end
   end

   always_comb begin
      estado_sig_s = estado_r;
      case (estado_r)
         REPOSO:   estado_sig_s = valido_s ? PETICION : REPOSO;
         PETICION: estado_sig_s = ack ? SERVICIO : PETICION;
         SERVICIO: estado_sig_s = fin ? REPOSO : SERVICIO;
         default:  estado_sig_s = REPOSO;
      endcase
   end

   // vector only moves when a request leaves REPOSO, so it is frozen through service
   always_comb begin
      irq_sig_s = (estado_sig_s == PETICION);
      if ((estado_r == REPOSO) && valido_s) begin
         vector_sig_s = indice_s;
      end else begin
         vector_sig_s = vector_r;
      end
   end

`ifdef CTRL_INT_PERDIDAS_EN
   logic [7:0] perdidas_r;
   logic [7:0] perdidos_s;

   always_comb begin
      perdidos_s = 8'h00;
      perdidos_s[N_FUENTES-1:0] = flanco_s & pendiente_r;
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         perdidas_r <= 8'h00;
      end else if (we && (dir == DIR_PERDIDAS)) begin
         perdidas_r <= 8'h00;
      end else begin
         perdidas_r <= suma_saturada(perdidas_r, cuenta_unos(perdidos_s));
      end
   end

   assign perdidas_lect_s = perdidas_r;
`else
   assign perdidas_lect_s = 8'h00;
`endif

   always_comb begin
      mascara_ext_s = 8'h00;
      mascara_ext_s[N_FUENTES-1:0] = mascara_r;
      pendiente_ext_s = 8'h00;
      pendiente_ext_s[N_FUENTES-1:0] = pendiente_r;
      case (dir)
         DIR_MASCARA:   dato_out = mascara_ext_s;
         DIR_PENDIENTE: dato_out = pendiente_ext_s;
         DIR_ESTADO:    dato_out = {3'b000, estado_r, vector_r};
         DIR_PERDIDAS:  dato_out = perdidas_lect_s;
         default:       dato_out = 8'h00;
      endcase
   end

   assign irq    = irq_r;
   assign vector = vector_r;

endmodule
